hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: RAW interlock against in-flight destinations
// plus decode squash after a control-flow redirect.
module hazard_unit #(
    parameter int STAGES       = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dec_valid,
    input  logic [3:0]  dec_s1_addr,
    input  logic        dec_s1_used,
    input  logic [3:0]  dec_s2_addr,
    input  logic        dec_s2_used,
    input  logic [3:0]  dec_dst_addr,
    input  logic        dec_wr_en,
    input  logic        redirect,
    output logic        bubble,
    output logic        pc_hold,
    output logic [15:0] stall_cycles
);

    localparam int FW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES);

    logic [STAGES-1:0] vld_q, vld_d;
    logic [3:0]        dst_q [STAGES];
    logic [3:0]        dst_d [STAGES];
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic [15:0]       stall_q, stall_d;

    logic s1_hit, s2_hit;
    logic raw, flush;

    // Compare both sources against every valid in-flight destination
    always_comb begin
        s1_hit = 1'b0;
        s2_hit = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (vld_q[k] && (dst_q[k] == dec_s1_addr)) s1_hit = 1'b1;
            if (vld_q[k] && (dst_q[k] == dec_s2_addr)) s2_hit = 1'b1;
        end
    end

    assign raw = dec_valid &
                 ((dec_s1_used & s1_hit) | (dec_s2_used & s2_hit));
    assign flush = redirect | (fcnt_q != '0);

    // Redirect wins: fetch moves on to the new PC instead of holding
    assign bubble       = raw | flush;
    assign pc_hold      = raw & ~flush;
    assign stall_cycles = stall_q;

    // Next state: shift scoreboard, run flush counter, count stalls
    always_comb begin
        vld_d    = '0;
        dst_d[0] = 4'd0;
        if (dec_valid && dec_wr_en && !bubble) begin
            vld_d[0] = 1'b1;
            dst_d[0] = dec_dst_addr;
        end
        for (int k = 1; k < STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
            dst_d[k] = dst_q[k-1];
        end

        fcnt_d = fcnt_q;
        if (redirect) begin
            fcnt_d = FLUSH_LOAD;
        end else if (fcnt_q != '0) begin
            fcnt_d = fcnt_q - 1'b1;
        end

        stall_d = stall_q;
        if (pc_hold && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q   <= '0;
            fcnt_q  <= '0;
            stall_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dst_q[k] <= 4'd0;
            end
        end else begin
            vld_q   <= vld_d;
            fcnt_q  <= fcnt_d;
            stall_q <= stall_d;
            for (int k = 0; k < STAGES; k++) begin
                dst_q[k] <= dst_d[k];
            end
        end
    end

endmodule
